// File: rtl/cim_scan_sequencer_if.sv
// Harness-side bus of the CIM scan sequencer: start/abort/data/run-count in, busy/done/result out.
// The master modport is the PS-side driver and the slave modport is the sequencer.
interface cim_scan_sequencer_if #(
    parameter int CHAIN_IN_LEN  = 128,
    parameter int CHAIN_OUT_LEN = 129,
    parameter int RUN_W         = 16
);
    logic                     har_start;
    logic                     har_abort;
    logic [CHAIN_IN_LEN-1:0]  har_scan_in_data;
    logic [RUN_W-1:0]         har_run_cycles;
    logic                     har_busy;
    logic                     har_done;
    logic [CHAIN_OUT_LEN-1:0] har_scan_out_data;

    modport master (
        output har_start, har_abort, har_scan_in_data, har_run_cycles,
        input  har_busy, har_done, har_scan_out_data
    );

    modport slave (
        input  har_start, har_abort, har_scan_in_data, har_run_cycles,
        output har_busy, har_done, har_scan_out_data
    );
endinterface

// File: rtl/cim_scan_sequencer.sv
// One full CIM scan transaction: shift in, update pulse, run, capture, shift out, report.
// Optional macro SCAN_OUT_SYNC_EN puts a 2-flop synchronizer on the scan-out pad (+2 cycles).
module cim_scan_sequencer #(
    parameter int CHAIN_IN_LEN  = 128,
    parameter int CHAIN_OUT_LEN = 129,
    parameter int UPD_HIGH_CYC  = 2,
    parameter int RUN_W         = 16
) (
    input  logic                i_har_clk,
    input  logic                i_har_reset_n,
    cim_scan_sequencer_if.slave har,
    output logic                o_cim_se_pad,
    output logic                o_cim_scan_in_pad,
    output logic                o_cim_update_clk_pad,
    input  logic                i_cim_scan_out_pad
);
`ifdef SCAN_OUT_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif
    localparam int UNLOAD_CYC = CHAIN_OUT_LEN + SYNC_DLY;
    localparam int MAX_A      = (CHAIN_IN_LEN > UNLOAD_CYC) ? CHAIN_IN_LEN : UNLOAD_CYC;
    localparam int CNT_MAX    = (MAX_A > UPD_HIGH_CYC) ? MAX_A : UPD_HIGH_CYC;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] IN_LAST     = CNT_W'(CHAIN_IN_LEN - 1);
    localparam logic [CNT_W-1:0] UPD_LAST_HI = CNT_W'(UPD_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] UPD_LOW     = CNT_W'(UPD_HIGH_CYC);
    localparam logic [CNT_W-1:0] SE_LAST     = CNT_W'(CHAIN_OUT_LEN - 1);
    localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(UNLOAD_CYC - 1);
    localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT_IN = 3'd1;
    localparam logic [2:0] S_UPDATE   = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_CAPTURE  = 3'd4;
    localparam logic [2:0] S_UNLOAD   = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [RUN_W-1:0]         r_run_cnt;
    logic [CHAIN_IN_LEN-1:0]  r_in_shift;
    logic [CHAIN_OUT_LEN-2:0] r_out_shift;
    logic [CHAIN_OUT_LEN-1:0] r_scan_out_data;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_se;
    logic                     r_scan_in;
    logic                     r_upd;
    logic                     w_scan_out_bit;
    logic                     w_sample_en;

`ifdef SCAN_OUT_SYNC_EN
    localparam logic [CNT_W-1:0] SAMPLE_FIRST = CNT_W'(SYNC_DLY);
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_har_clk or negedge i_har_reset_n) begin
        if (!i_har_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_cim_scan_out_pad;
            r_sync2 <= r_sync1;
        end
    end

    // The first SYNC_DLY unload cycles only flush the synchronizer.
    assign w_scan_out_bit = r_sync2;
    assign w_sample_en    = (r_cnt >= SAMPLE_FIRST);
`else
    assign w_scan_out_bit = i_cim_scan_out_pad;
    assign w_sample_en    = 1'b1;
`endif

    always_ff @(posedge i_har_clk or negedge i_har_reset_n) begin
        if (!i_har_reset_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_run_cnt       <= '0;
            r_in_shift      <= '0;
            r_out_shift     <= '0;
            r_scan_out_data <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_se            <= 1'b0;
            r_scan_in       <= 1'b0;
            r_upd           <= 1'b0;
        end else if (har.har_abort) begin
            // Abort beats start and every transition; the last result is kept.
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_se      <= 1'b0;
            r_scan_in <= 1'b0;
            r_upd     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (har.har_start) begin
                        r_in_shift <= har.har_scan_in_data;
                        r_run_cnt  <= har.har_run_cycles;
                        r_scan_in  <= har.har_scan_in_data[0];
                        r_se       <= 1'b1;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_SHIFT_IN;
                    end
                end
                S_SHIFT_IN: begin
                    if (r_cnt == IN_LAST) begin
                        r_se      <= 1'b0;
                        r_scan_in <= 1'b0;
                        r_upd     <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_UPDATE;
                    end else begin
                        r_in_shift <= r_in_shift >> 1;
                        r_scan_in  <= r_in_shift[1];
                        r_cnt      <= r_cnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == UPD_LAST_HI) begin
                        r_upd <= 1'b0;
                    end
                    if (r_cnt == UPD_LOW) begin
                        r_cnt   <= '0;
                        r_state <= (r_run_cnt == '0) ? S_CAPTURE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_run_cnt == RUN_ONE) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_run_cnt <= r_run_cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_se    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_UNLOAD;
                end
                S_UNLOAD: begin
                    if (w_sample_en) begin
                        r_out_shift <= {w_scan_out_bit, r_out_shift[CHAIN_OUT_LEN-2:1]};
                    end
                    if (r_cnt == UNLOAD_LAST) begin
                        r_scan_out_data <= {w_scan_out_bit, r_out_shift};
                        r_done          <= 1'b1;
                        r_busy          <= 1'b0;
                        r_se            <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == SE_LAST) begin
                            r_se <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign har.har_busy          = r_busy;
    assign har.har_done          = r_done;
    assign har.har_scan_out_data = r_scan_out_data;
    assign o_cim_se_pad          = r_se;
    assign o_cim_scan_in_pad     = r_scan_in;
    assign o_cim_update_clk_pad  = r_upd;
endmodule

// File: tb/tb_cim_scan_sequencer.sv
// Bench for cim_scan_sequencer: behavioural CIM loopback chain, vector table, corner sequences,
// and randomized transactions against an arithmetic latency/result model.
module tb_cim_scan_sequencer;
    localparam int IN_LEN  = 128;
    localparam int OUT_LEN = 129;
    localparam int UPD     = 2;
    localparam int RUN_W   = 16;
`ifdef SCAN_OUT_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    // Start is cycle 0; done is observed in cycle LAT0 + run_cycles (262 without sync).
    localparam int LAT0 = IN_LEN + UPD + 1 + 1 + OUT_LEN + 1 + SYNC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic se, scan_in, upd, scan_out;

    always #5 clk = ~clk;

    cim_scan_sequencer_if #(.CHAIN_IN_LEN(IN_LEN), .CHAIN_OUT_LEN(OUT_LEN), .RUN_W(RUN_W)) har_if ();

    cim_scan_sequencer #(
        .CHAIN_IN_LEN(IN_LEN), .CHAIN_OUT_LEN(OUT_LEN), .UPD_HIGH_CYC(UPD), .RUN_W(RUN_W)
    ) dut (
        .i_har_clk(clk),
        .i_har_reset_n(rst_n),
        .har(har_if),
        .o_cim_se_pad(se),
        .o_cim_scan_in_pad(scan_in),
        .o_cim_update_clk_pad(upd),
        .i_cim_scan_out_pad(scan_out)
    );

    // CIM model: input chain shifts toward bit 0, update latches it, output chain
    // reloads {parity, latched word} whenever scan enable is low.
    logic [IN_LEN-1:0]  cim_in_chain  = '0;
    logic [IN_LEN-1:0]  cim_latch     = '0;
    logic [OUT_LEN-1:0] cim_out_chain = '0;

    always @(posedge clk) begin
        if (se) begin
            cim_in_chain  <= {scan_in, cim_in_chain[IN_LEN-1:1]};
            cim_out_chain <= {1'b0, cim_out_chain[OUT_LEN-1:1]};
        end else begin
            cim_out_chain <= {^cim_latch, cim_latch};
        end
        if (upd) cim_latch <= cim_in_chain;
    end
    assign scan_out = cim_out_chain[0];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [IN_LEN-1:0]  data;
        logic [RUN_W-1:0]   run;
        bit                 extra_start;
        logic [OUT_LEN-1:0] exp_out;
        int                 exp_lat;
    } vec_t;
    vec_t vecs[4];

    int m_lat, m_shift_se, m_upd_high, m_gap, m_unload_se, m_done_cnt;
    int m_scanin_bad, m_busy_low, m_done_busy, m_post_busy;
    logic [IN_LEN-1:0] m_word;
    bit m_timeout, m_aborted;
    logic m_ab_se, m_ab_busy, m_ab_pads, m_ab_done;

    task automatic run_txn(input logic [IN_LEN-1:0] data, input logic [RUN_W-1:0] run,
                           input int abort_idx, input bit extra_start);
        int phase, fall_cyc, budget;
        phase = 0; fall_cyc = -1; budget = LAT0 + int'(run) + 40;
        m_lat = -1; m_shift_se = 0; m_upd_high = 0; m_gap = -1; m_unload_se = 0;
        m_done_cnt = 0; m_scanin_bad = 0; m_busy_low = 0; m_done_busy = -1; m_post_busy = 0;
        m_word = '0; m_timeout = 0; m_aborted = 0;
        @(negedge clk);
        har_if.har_scan_in_data = data;
        har_if.har_run_cycles   = run;
        har_if.har_start        = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            har_if.har_start = (extra_start && c == 50);
            if (!har_if.har_busy && !har_if.har_done) m_busy_low++;
            if (phase == 0 && se) phase = 1;
            else if (phase == 1 && !se) phase = 2;
            else if (phase == 2 && se) begin
                phase = 3;
                m_gap = c - fall_cyc;
            end
            if (phase == 1) begin
                if (m_shift_se < IN_LEN) m_word[m_shift_se] = scan_in;
                m_shift_se++;
            end
            if (upd) m_upd_high++;
            else if (m_upd_high > 0 && fall_cyc < 0) fall_cyc = c;
            if (phase == 3 && se) begin
                m_unload_se++;
                if (scan_in) m_scanin_bad++;
            end
            if (har_if.har_done) begin
                m_done_cnt++;
                m_lat = c;
                m_done_busy = int'(har_if.har_busy);
                break;
            end
            if (phase == 3 && se && m_unload_se - 1 == abort_idx) begin
                har_if.har_abort = 1'b1;
                @(negedge clk);
                har_if.har_abort = 1'b0;
                m_ab_se = se; m_ab_busy = har_if.har_busy;
                m_ab_pads = se | scan_in | upd; m_ab_done = har_if.har_done;
                m_aborted = 1;
                break;
            end
        end
        if (m_lat < 0 && !m_aborted) m_timeout = 1;
        if (!m_aborted) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (har_if.har_done) m_done_cnt++;
                if (har_if.har_busy || se) m_post_busy++;
            end
        end
    endtask

    task automatic check_txn(input string tag, input logic [IN_LEN-1:0] data,
                             input logic [RUN_W-1:0] run, input logic [OUT_LEN-1:0] exp_out,
                             input int exp_lat);
        check({tag, " timeout"}, m_timeout, 0);
        check({tag, " shift_se_cycles"}, m_shift_se, IN_LEN);
        check({tag, " shift_word"}, m_word, data);
        check({tag, " update_high"}, m_upd_high, UPD);
        check({tag, " update_to_unload"}, m_gap, int'(run) + 2);
        check({tag, " unload_se_cycles"}, m_unload_se, OUT_LEN);
        check({tag, " scan_in_in_unload"}, m_scanin_bad, 0);
        check({tag, " busy_during"}, m_busy_low, 0);
        check({tag, " done_count"}, m_done_cnt, 1);
        check({tag, " busy_at_done"}, m_done_busy, 0);
        check({tag, " idle_after"}, m_post_busy, 0);
        check({tag, " latency"}, m_lat, exp_lat);
        check({tag, " scan_out_data"}, har_if.har_scan_out_data, exp_out);
        $display("txn %s run=%0d latency=%0d out=%h", tag, run, m_lat, har_if.har_scan_out_data);
    endtask

    initial begin
        logic [IN_LEN-1:0]  rdata;
        logic [RUN_W-1:0]   rrun;
        logic [OUT_LEN-1:0] prev_out;
        int cnt;

        har_if.har_start = 1'b0;
        har_if.har_abort = 1'b0;
        har_if.har_scan_in_data = '0;
        har_if.har_run_cycles = '0;

        vecs[0] = '{data: 128'h1, run: 16'd0, extra_start: 1'b0,
                    exp_out: {1'b1, 128'h1}, exp_lat: LAT0};
        vecs[1] = '{data: {1'b1, 127'h0}, run: 16'd0, extra_start: 1'b0,
                    exp_out: {1'b1, 1'b1, 127'h0}, exp_lat: LAT0};
        vecs[2] = '{data: {4{32'hA5A5A5A5}}, run: 16'd0, extra_start: 1'b0,
                    exp_out: {1'b0, {4{32'hA5A5A5A5}}}, exp_lat: LAT0};
        vecs[3] = '{data: 128'h0123456789ABCDEF_FEDCBA9876543210, run: 16'd5, extra_start: 1'b1,
                    exp_out: {1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210}, exp_lat: LAT0 + 5};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", har_if.har_busy, 0);
        check("reset done", har_if.har_done, 0);
        check("reset data", har_if.har_scan_out_data, 0);
        check("reset pads", {se, scan_in, upd}, 0);
        rst_n = 1'b1;

        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (har_if.har_busy || se) cnt++;
        end
        check("idle_no_start", cnt, 0);

        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].data, vecs[i].run, -1, vecs[i].extra_start);
            check_txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].run, vecs[i].exp_out,
                      vecs[i].exp_lat);
        end

        // Abort in unload se-cycle 40
        prev_out = har_if.har_scan_out_data;
        run_txn({4{32'h3C3C_1234}}, 16'd2, 40, 1'b0);
        check("abort reached", m_aborted, 1);
        check("abort se", m_ab_se, 0);
        check("abort busy", m_ab_busy, 0);
        check("abort pads", m_ab_pads, 0);
        check("abort done", m_ab_done, 0);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (har_if.har_done || har_if.har_busy || se) cnt++;
        end
        check("abort quiet", cnt, 0);
        check("abort keeps data", har_if.har_scan_out_data, vecs[3].exp_out);
        $display("txn abort keep=%h", prev_out);

        // Start and abort together in IDLE
        @(negedge clk);
        har_if.har_start = 1'b1;
        har_if.har_abort = 1'b1;
        @(negedge clk);
        har_if.har_start = 1'b0;
        har_if.har_abort = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (har_if.har_busy || se) cnt++;
            @(negedge clk);
        end
        check("start_abort_idle", cnt, 0);
        $display("txn start+abort idle ignored");

        // Randomized transactions against the parity-loopback model
        for (int i = 0; i < 8; i++) begin
            rdata = {$urandom, $urandom, $urandom, $urandom};
            rrun  = RUN_W'($urandom_range(0, 12));
            run_txn(rdata, rrun, -1, 1'b0);
            check_txn($sformatf("rnd%0d", i), rdata, rrun, {^rdata, rdata}, LAT0 + int'(rrun));
        end

        // Reset mid-transaction: pads drop without waiting for a clock edge
        @(negedge clk);
        har_if.har_scan_in_data = '1;
        har_if.har_run_cycles = 16'd0;
        har_if.har_start = 1'b1;
        @(negedge clk);
        har_if.har_start = 1'b0;
        repeat (60) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset pads", {se, scan_in, upd}, 0);
        check("async reset busy", har_if.har_busy, 0);
        check("async reset data", har_if.har_scan_out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn mid-transaction reset");

        run_txn(vecs[2].data, vecs[2].run, -1, 1'b0);
        check_txn("post_reset", vecs[2].data, vecs[2].run, vecs[2].exp_out, vecs[2].exp_lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
